jtkiwi_shr_bridge: RTL

- Sub (sound) CPU side of the main/sub shared-RAM port.
- Turns sub-CPU bus cycles that the parent has already decoded as shared-RAM hits into shr_cs/shr_addr/shr_din/sub_rnw requests toward the main CPU block, and holds the sub CPU on wait_n until access is granted.
- Grant is inferred from mshramen using the main block's first-come-first-served rule; read data is captured from shr_dout.
- Sits in the sound subsystem between the sub Z80 wrapper and the main CPU block.

---
 rtl/jtkiwi_shr_pkg.sv | 23 ++
 rtl/jtkiwi_shr_bridge_if.sv | 34 +++
 rtl/jtkiwi_shr_bridge.sv | 128 ++++++++++++
 3 files changed

// File: rtl/jtkiwi_shr_pkg.sv
// Shared definitions for the sub-CPU side of the main/sub shared-RAM port:
// FSM state encoding, bus widths and the latched request payload.
package jtkiwi_shr_pkg;

  localparam int unsigned SHR_AW = 13;
  localparam int unsigned SHR_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DONE = 3'd3,
    ST_REL  = 3'd4
  } shr_state_e;

  // Request held stable toward the main block from ARB entry to IDLE
  typedef struct packed {
    logic              rnw;
    logic [SHR_AW-1:0] addr;
    logic [SHR_DW-1:0] data;
  } shr_req_t;

endpackage

// File: rtl/jtkiwi_shr_bridge_if.sv
// Bus bundle between the sub Z80 wrapper, the bridge and the main CPU block.
//   cpu_*    : decoded sub-CPU shared-RAM cycle, read data and WAIT
//   shr_*    : request / address / write data toward the main block
//   sub_rnw  : shared-RAM direction for the sub side
//   mshramen : main CPU currently owns the RAM
//   shr_dout : registered shared-RAM read port
// slave  : the bridge's view; master : the surrounding system's view.
interface jtkiwi_shr_bridge_if;
  import jtkiwi_shr_pkg::*;

  logic              cpu_cs;
  logic              cpu_rnw;
  logic [SHR_AW-1:0] cpu_addr;
  logic [SHR_DW-1:0] cpu_dout;
  logic [SHR_DW-1:0] cpu_din;
  logic              wait_n;
  logic              shr_cs;
  logic [SHR_AW-1:0] shr_addr;
  logic [SHR_DW-1:0] shr_din;
  logic              sub_rnw;
  logic              mshramen;
  logic [SHR_DW-1:0] shr_dout;

  modport slave (
    input  cpu_cs, cpu_rnw, cpu_addr, cpu_dout, mshramen, shr_dout,
    output cpu_din, wait_n, shr_cs, shr_addr, shr_din, sub_rnw
  );

  modport master (
    output cpu_cs, cpu_rnw, cpu_addr, cpu_dout, mshramen, shr_dout,
    input  cpu_din, wait_n, shr_cs, shr_addr, shr_din, sub_rnw
  );

endinterface

// File: rtl/jtkiwi_shr_bridge.sv
// Sub-CPU side of the main/sub shared-RAM port. Converts a decoded sub-CPU
// shared-RAM cycle into a held request toward the main block, infers the
// grant from mshramen staying low for GNT_LEN samples, captures read data
// and stalls the sub CPU on wait_n until the access has completed.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave view of jtkiwi_shr_bridge_if (CPU and shared-RAM side)
//   stall_err  : sticky, arbitration lasted TMO cycles without a grant
//   st_dout    : debug {stall_err, 2'd0, gcnt[1:0], state[2:0]}
module jtkiwi_shr_bridge
  import jtkiwi_shr_pkg::*;
#(
  parameter int unsigned TMO     = 255,
  parameter int unsigned GNT_LEN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  jtkiwi_shr_bridge_if.slave  bus,
  output logic                stall_err,
  output logic [7:0]          st_dout
);

  localparam int unsigned TW = $clog2(TMO + 1);
  // gcnt is at least 2 bits wide so the debug view can always show gcnt[1:0]
  localparam int unsigned GW = ($clog2(GNT_LEN + 1) < 2) ? 2 : $clog2(GNT_LEN + 1);

  shr_state_e        state_q, state_d;
  shr_req_t          req_q, req_d;
  logic              shr_cs_q, shr_cs_d;
  logic [SHR_DW-1:0] cpu_din_q, cpu_din_d;
  logic              stall_err_q, stall_err_d;
  logic [GW-1:0]     gcnt_q, gcnt_d, gcnt_inc;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '{rnw: 1'b1, addr: '0, data: '0};
      shr_cs_q    <= 1'b0;
      cpu_din_q   <= '0;
      stall_err_q <= 1'b0;
      gcnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      shr_cs_q    <= shr_cs_d;
      cpu_din_q   <= cpu_din_d;
      stall_err_q <= stall_err_d;
      gcnt_q      <= gcnt_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Next-state, request latch, grant/timeout counters
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    shr_cs_d    = shr_cs_q;
    cpu_din_d   = cpu_din_q;
    stall_err_d = stall_err_q;
    gcnt_d      = gcnt_q;
    tcnt_d      = tcnt_q;
    gcnt_inc    = gcnt_q + GW'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_cs) begin
          req_d    = '{rnw: bus.cpu_rnw, addr: bus.cpu_addr, data: bus.cpu_dout};
          shr_cs_d = 1'b1;
          gcnt_d   = '0;
          tcnt_d   = '0;
          state_d  = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!bus.cpu_cs) begin
          shr_cs_d  = 1'b0;
          req_d.rnw = 1'b1;
          state_d   = ST_REL;
        end else begin
          if (tcnt_q != TW'(TMO)) begin
            tcnt_d = tcnt_q + TW'(1);
            if (tcnt_q == TW'(TMO - 1)) stall_err_d = 1'b1;
          end
          // Any main-side ownership sample restarts the grant count
          if (bus.mshramen) begin
            gcnt_d = '0;
          end else begin
            gcnt_d = gcnt_inc;
            if (gcnt_inc == GW'(GNT_LEN)) state_d = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (!bus.cpu_cs) begin
          shr_cs_d  = 1'b0;
          req_d.rnw = 1'b1;
          state_d   = ST_REL;
        end else begin
          if (req_q.rnw) cpu_din_d = bus.shr_dout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.cpu_cs) begin
          shr_cs_d  = 1'b0;
          req_d.rnw = 1'b1;
          state_d   = ST_REL;
        end
      end
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // WAIT is released only once the access is done; forced high in reset
  assign bus.wait_n   = ~rst_n | ~(bus.cpu_cs & (state_q != ST_DONE));
  assign bus.shr_cs   = shr_cs_q;
  assign bus.shr_addr = req_q.addr;
  assign bus.shr_din  = req_q.data;
  assign bus.sub_rnw  = req_q.rnw;
  assign bus.cpu_din  = cpu_din_q;
  assign stall_err    = stall_err_q;
  assign st_dout      = {stall_err_q, 2'b00, gcnt_q[1:0], state_q};

endmodule
